// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and bypassed operands for EX,
// detects load-use hazards, handles branch flush and keeps saturating hazard statistics.
module id_ex_stage #(
  parameter int CTRL_W      = 8,
  parameter int CTRL_RW_BIT = 0,
  parameter int CTRL_MR_BIT = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_w_add,
  input  logic [31:0]       wb_data,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_data1,
  output logic [31:0]       ex_data2,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit indices must land inside the bundle and must not alias each other.
  if (CTRL_MR_BIT >= CTRL_W || CTRL_RW_BIT >= CTRL_W || CTRL_RW_BIT == CTRL_MR_BIT) begin : g_bad_ctrl_idx
    $error("id_ex_stage: invalid control bit indices");
  end

  logic [31:0] byp1;
  logic [31:0] byp2;
  logic        dep_rs1;
  logic        dep_rs2;
  logic        lu;

  // The register file writes on the same edge EX captures, so a same-cycle WB
  // write must be forwarded or ID would read the stale value.
  always_comb begin
    byp1 = rf_data1;
    if (id_rs1 == 5'd0)
      byp1 = '0;
    else if (wb_RegWrite && (wb_w_add == id_rs1))
      byp1 = wb_data;
  end

  always_comb begin
    byp2 = rf_data2;
    if (id_rs2 == 5'd0)
      byp2 = '0;
    else if (wb_RegWrite && (wb_w_add == id_rs2))
      byp2 = wb_data;
  end

  assign dep_rs1 = id_uses_rs1 && (ex_rd == id_rs1);
  assign dep_rs2 = id_uses_rs2 && (ex_rd == id_rs2);
  assign lu      = id_valid && ex_valid && ex_ctrl[CTRL_MR_BIT] && (ex_rd != 5'd0)
                   && (dep_rs1 || dep_rs2);

  // A flushed ID instruction is dead, so it never needs to wait.
  assign stall = lu && !ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_data1  <= '0;
      ex_data2  <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (ex_flush || stall) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
      if (ex_flush) begin
        if (id_valid && (flush_cnt != CNT_MAX))
          flush_cnt <= flush_cnt + CNT_ONE;
      end else if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_data1 <= byp1;
      ex_data2 <= byp2;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/bypass scenarios plus a
// randomized run against a cycle-level reference model of the EX slot.
module tb_id_ex_stage;
  localparam int CTRL_W = 8;
  localparam int RW     = 0;
  localparam int MR     = 1;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int VW     = 1 + 32 + 15 + 96 + CTRL_W + 2 * CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       rf_data1, rf_data2;
  logic              wb_RegWrite;
  logic [4:0]        wb_w_add;
  logic [31:0]       wb_data;
  logic              ex_flush;
  logic              stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [31:0]       ex_data1, ex_data2, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(
    .CTRL_W(CTRL_W), .CTRL_RW_BIT(RW), .CTRL_MR_BIT(MR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_RegWrite(wb_RegWrite), .wb_w_add(wb_w_add), .wb_data(wb_data),
    .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of what the EX slot should hold.
  logic              m_valid;
  logic [31:0]       m_pc, m_d1, m_d2, m_imm;
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_scnt, m_fcnt;

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (wb_RegWrite && wb_w_add == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic model_stall();
    logic reads_load;
    reads_load = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
    return !ex_flush && id_valid && m_valid && m_ctrl[MR] && m_rd != 5'd0 && reads_load;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_valid, m_pc, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_ctrl,
            CNT_W'(m_scnt), CNT_W'(m_fcnt)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm, ex_ctrl,
            stall_cnt, flush_cnt};
  endfunction

  task automatic clear_slot();
    m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    logic s;
    @(posedge clk);
    s = model_stall();
    if (rst) begin
      clear_slot();
      m_scnt = 0;
      m_fcnt = 0;
    end else if (ex_flush) begin
      clear_slot();
      if (id_valid && m_fcnt < CMAX) m_fcnt++;
    end else if (s) begin
      clear_slot();
      if (m_scnt < CMAX) m_scnt++;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = operand(id_rs1, rf_data1); m_d2 = operand(id_rs2, rf_data2);
      m_imm = id_imm; m_ctrl = id_valid ? id_ctrl : '0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_imm = 0; id_ctrl = 0;
    rf_data1 = 0; rf_data2 = 0; wb_RegWrite = 0; wb_w_add = 0; wb_data = 0; ex_flush = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic put_load(input logic [4:0] rd, input logic [4:0] rs1);
    id_valid = 1; id_pc = 32'h100; id_rd = rd; id_rs1 = rs1; id_uses_rs1 = 1;
    id_rs2 = 0; id_uses_rs2 = 0; id_ctrl = 8'h03; id_imm = 32'h4;
  endtask

  task automatic put_add(input logic [4:0] rs1, input logic use1);
    id_valid = 1; id_pc = 32'h104; id_rd = 5'd7; id_rs1 = rs1; id_uses_rs1 = use1;
    id_rs2 = 5'd6; id_uses_rs2 = 1; id_ctrl = 8'h01; id_imm = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    id_valid = 1; id_pc = $urandom; id_rd = 5'd9; id_ctrl = 8'hff; id_imm = $urandom;
    rst = 1; tick(); tick();
    rst = 0; idle_inputs(); #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", stall);
    end
  endtask

  task automatic test_bypass();
    logic [4:0] waddr [3] = '{5'd1, 5'd2, 5'd0};
    logic [31:0] want [3] = '{32'd55, 32'd10, 32'd0};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_rs1 = (i == 2) ? 5'd0 : 5'd1; rf_data1 = 32'd10;
      wb_RegWrite = 1; wb_w_add = waddr[i]; wb_data = (i == 2) ? 32'd99 : 32'd55;
      tick();
      checks++;
      if (ex_data1 !== want[i]) begin
        errors++; $display("FAIL bypass_%0d got %0d want %0d", i, ex_data1, want[i]);
      end
    end
    // rs2 path: WB to x3 forwarded onto operand 2.
    id_rs2 = 5'd3; rf_data2 = 32'h1111; wb_w_add = 5'd3; wb_data = 32'hbeef;
    tick();
    checks++;
    if (ex_data2 !== 32'hbeef || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL bypass_rs2 got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_load_use();
    pulse_reset();
    put_load(5'd5, 5'd1); tick();
    put_add(5'd5, 1'b1); #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %b want 1", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_bubble got v=%b ctrl=%h cnt=%0d want v=0 ctrl=0 cnt=1",
                         ex_valid, ex_ctrl, stall_cnt);
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_release got %b want 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd7 || ex_ctrl !== 8'h01) begin
      errors++; $display("FAIL lu_enter got v=%b rs1=%0d rd=%0d ctrl=%h want v=1 rs1=5 rd=7 ctrl=01",
                         ex_valid, ex_rs1, ex_rd, ex_ctrl);
    end
  endtask

  task automatic test_no_use();
    pulse_reset();
    put_load(5'd5, 5'd1); tick();
    put_add(5'd5, 1'b0); #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL nouse_stall got %b want 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL nouse_enter got v=%b cnt=%0d want v=1 cnt=0", ex_valid, stall_cnt);
    end
  endtask

  task automatic test_flush_during_stall();
    pulse_reset();
    put_load(5'd5, 5'd1); tick();
    put_add(5'd5, 1'b1); ex_flush = 1; #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %b want 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL flush_bubble got v=%b ctrl=%h fc=%0d sc=%0d want v=0 ctrl=0 fc=1 sc=0",
                         ex_valid, ex_ctrl, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    put_load(5'd5, 5'd1); tick();
    put_add(5'd5, 1'b1); rst = 1; tick(); rst = 0; #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stall got stall=%b v=%b want 0 0", stall, ex_valid);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      id_valid = ($urandom_range(0, 9) < 8);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_ctrl = 8'($urandom);
      id_ctrl[MR] = ($urandom_range(0, 9) < 5);
      rf_data1 = $urandom; rf_data2 = $urandom;
      wb_RegWrite = 1'($urandom); wb_w_add = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++; $display("FAIL rand_stall cyc %0d got %b want %b", i, stall, model_stall());
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rand_state cyc %0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    pulse_reset();
    put_load(5'd5, 5'd5);
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (stall_cnt !== 4'hf || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL stall_sat got cnt=%0d want 15", stall_cnt);
    end
    idle_inputs(); id_valid = 1; ex_flush = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (flush_cnt !== 4'hf || stall_cnt !== 4'hf) begin
      errors++; $display("FAIL flush_sat got fc=%0d sc=%0d want 15 15", flush_cnt, stall_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    clear_slot(); m_scnt = 0; m_fcnt = 0;
    test_reset();
    test_bypass();
    test_load_use();
    test_no_use();
    test_flush_during_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
